// File: rtl/div_issue_ctrl.sv
// rtl/div_issue_ctrl.sv - RV32M divide issue/response controller; optional DIV_RESULT_CACHE_EN result cache
module div_issue_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_flush,
  output logic        o_stall,
  output logic        o_valid,
  output logic [31:0] o_result,
  output logic        o_timeout,
  output logic        o_div_valid,
  output logic [31:0] o_div_a,
  output logic [31:0] o_div_b,
  input  logic        i_div_valid,
  input  logic [31:0] i_div_quotient,
  input  logic [31:0] i_div_remainder
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t            state;
  logic              op_rem;
  logic              sq;
  logic              sr;
  logic [31:0]       res;
  logic              to_q;
  logic              drain;
  logic [CNT_W-1:0]  cnt;

  logic              is_signed;
  logic              accept;
  logic              special_zero;
  logic              special_ovf;
  logic [31:0]       abs_a;
  logic [31:0]       abs_b;
  logic [CNT_W-1:0]  cnt_next;
  logic              cnt_expire;
  logic [31:0]       q_fix;
  logic [31:0]       r_fix;
  logic              cache_hit;
  logic [31:0]       cache_res;

  assign is_signed    = ~i_op[0];
  assign accept       = i_valid && o_ready && !i_flush;
  assign special_zero = (i_b == 32'd0);
  assign special_ovf  = is_signed && (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);
  // Two's complement negate: 0x80000000 maps onto itself, which the unsigned divider handles.
  assign abs_a        = (is_signed && i_a[31]) ? (32'd0 - i_a) : i_a;
  assign abs_b        = (is_signed && i_b[31]) ? (32'd0 - i_b) : i_b;
  assign cnt_next     = cnt + 1'b1;
  assign cnt_expire   = (cnt_next == CNT_W'(TIMEOUT_CYCLES - 1));
  assign q_fix        = sq ? (32'd0 - i_div_quotient) : i_div_quotient;
  assign r_fix        = sr ? (32'd0 - i_div_remainder) : i_div_remainder;

`ifdef DIV_RESULT_CACHE_EN
  logic        c_valid;
  logic [31:0] c_a;
  logic [31:0] c_b;
  logic        c_signed;
  logic [31:0] c_q;
  logic [31:0] c_r;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        s_q;

  assign cache_hit = c_valid && (c_a == i_a) && (c_b == i_b) && (c_signed == is_signed);
  assign cache_res = i_op[1] ? c_r : c_q;

  // Remember operands of the request in flight and record its final results on a clean completion
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      c_valid  <= 1'b0;
      c_a      <= '0;
      c_b      <= '0;
      c_signed <= 1'b0;
      c_q      <= '0;
      c_r      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= 1'b0;
    end else begin
      if (accept) begin
        a_q <= i_a;
        b_q <= i_b;
        s_q <= is_signed;
      end
      if (state == S_WAIT && !i_flush && i_div_valid) begin
        c_valid  <= 1'b1;
        c_a      <= a_q;
        c_b      <= b_q;
        c_signed <= s_q;
        c_q      <= q_fix;
        c_r      <= r_fix;
      end
    end
  end
`else
  assign cache_hit = 1'b0;
  assign cache_res = 32'd0;
`endif

  // Control FSM with registered handshake, stall and result outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      op_rem      <= 1'b0;
      sq          <= 1'b0;
      sr          <= 1'b0;
      res         <= '0;
      to_q        <= 1'b0;
      drain       <= 1'b0;
      cnt         <= '0;
      o_ready     <= 1'b1;
      o_stall     <= 1'b0;
      o_valid     <= 1'b0;
      o_result    <= '0;
      o_timeout   <= 1'b0;
      o_div_valid <= 1'b0;
      o_div_a     <= '0;
      o_div_b     <= '0;
    end else begin
      o_div_valid <= 1'b0;
      o_valid     <= 1'b0;
      o_timeout   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (drain) begin
            // A flushed request is still owned by the divider; wait it out.
            cnt <= cnt_next;
            if (i_div_valid || cnt_expire) begin
              drain   <= 1'b0;
              o_ready <= 1'b1;
              o_stall <= 1'b0;
            end
          end else if (accept) begin
            op_rem  <= i_op[1];
            sq      <= is_signed && (i_a[31] ^ i_b[31]);
            sr      <= is_signed && i_a[31];
            to_q    <= 1'b0;
            o_ready <= 1'b0;
            if (special_zero) begin
              res     <= i_op[1] ? i_a : 32'hFFFF_FFFF;
              state   <= S_DONE;
            end else if (special_ovf) begin
              res     <= i_op[1] ? 32'd0 : 32'h8000_0000;
              state   <= S_DONE;
            end else if (cache_hit) begin
              res     <= cache_res;
              state   <= S_DONE;
            end else begin
              o_div_a     <= abs_a;
              o_div_b     <= abs_b;
              o_div_valid <= 1'b1;
              o_stall     <= 1'b1;
              state       <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          cnt <= '0;
          if (i_flush) begin
            state   <= S_IDLE;
            o_ready <= 1'b1;
            o_stall <= 1'b0;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt <= cnt_next;
          if (i_flush) begin
            state <= S_IDLE;
            if (i_div_valid || cnt_expire) begin
              o_ready <= 1'b1;
              o_stall <= 1'b0;
            end else begin
              drain <= 1'b1;
            end
          end else if (i_div_valid) begin
            res     <= op_rem ? r_fix : q_fix;
            o_stall <= 1'b0;
            state   <= S_DONE;
          end else if (cnt_expire) begin
            res     <= 32'd0;
            to_q    <= 1'b1;
            o_stall <= 1'b0;
            state   <= S_DONE;
          end
        end
        default: begin
          state   <= S_IDLE;
          o_ready <= 1'b1;
          o_stall <= 1'b0;
          if (!i_flush) begin
            o_valid   <= 1'b1;
            o_timeout <= to_q;
            o_result  <= res;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb/tb_div_issue_ctrl.sv - scoreboard bench for div_issue_ctrl
module tb_div_issue_ctrl;
  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [1:0]  i_op = 2'b00;
  logic [31:0] i_a = '0;
  logic [31:0] i_b = '0;
  logic        i_flush = 1'b0;
  logic        o_stall;
  logic        o_valid;
  logic [31:0] o_result;
  logic        o_timeout;
  logic        o_div_valid;
  logic [31:0] o_div_a;
  logic [31:0] o_div_b;
  logic        i_div_valid = 1'b0;
  logic [31:0] i_div_quotient = '0;
  logic [31:0] i_div_remainder = '0;

  div_issue_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(7)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_a(i_a), .i_b(i_b), .i_flush(i_flush), .o_stall(o_stall),
    .o_valid(o_valid), .o_result(o_result), .o_timeout(o_timeout),
    .o_div_valid(o_div_valid), .o_div_a(o_div_a), .o_div_b(o_div_b),
    .i_div_valid(i_div_valid), .i_div_quotient(i_div_quotient),
    .i_div_remainder(i_div_remainder)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        to;
    int          due;
  } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  int          dlat = 4;
  bit          div_en = 1'b1;
  int          resp_cnt = 0;
  int          pulses = 0;
  logic [31:0] la = '0;
  logic [31:0] lb = '0;

  bit          cache_on = 1'b0;
  bit          cv = 1'b0;
  logic [31:0] ca, cb;
  bit          cs;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Divider model: responds dlat cycles after sampling a request
  initial begin
    forever begin
      @(negedge clk);
      i_div_valid = 1'b0;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          i_div_valid     = 1'b1;
          i_div_quotient  = (lb != 0) ? la / lb : 32'd0;
          i_div_remainder = (lb != 0) ? la % lb : la;
        end
      end
      if (o_div_valid === 1'b1) begin
        pulses++;
        la = o_div_a;
        lb = o_div_b;
        if (div_en) resp_cnt = dlat;
      end
    end
  end

  // Monitor: pops the scoreboard whenever a result is presented
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (o_valid === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("result", o_result, e.res);
          chk("timeout_flag", {31'd0, o_timeout}, {31'd0, e.to});
          chk("latency_cycle", cyc, e.due);
        end
      end else if (o_timeout === 1'b1) begin
        chk("timeout_without_valid", 32'd1, 32'd0);
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (o_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {31'd0, (n < 300)}, 32'd1);
  endtask

  task automatic do_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input bit to);
    int n, p0, lat;
    bit sp, hit;
    exp_t e;
    sp  = (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    hit = cache_on && cv && ca == a && cb == b && cs == !op[0];
    lat = to ? TO + 1 : ((sp || hit) ? 1 : dlat + 2);
    wait_ready();
    p0 = pulses;
    i_op = op; i_a = a; i_b = b; i_valid = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    e.res = res; e.to = to; e.due = cyc + lat;
    sb.push_back(e);
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) sb.delete();
    chk("result_wait", {31'd0, (n < 300)}, 32'd1);
    chk("div_pulses", pulses - p0, (sp || hit) ? 0 : 1);
    if (!sp && !hit && !to) begin
      cv = 1'b1; ca = a; cb = b; cs = !op[0];
    end
  endtask

  initial begin
    int n, p0;
`ifdef DIV_RESULT_CACHE_EN
    cache_on = 1'b1;
`endif
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, o_ready}, 32'd1);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_stall", {31'd0, o_stall}, 32'd0);
    chk("rst_div_valid", {31'd0, o_div_valid}, 32'd0);
    chk("rst_result", o_result, 32'd0);
    rst_n = 1'b1;

    do_req(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
    chk("div_a_mag", la, 32'd7);
    chk("div_b_mag", lb, 32'd2);
    do_req(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
    do_req(2'b11, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 1'b0);
    do_req(2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0);
    do_req(2'b10, 32'd5, 32'd0, 32'd5, 1'b0);
    do_req(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    do_req(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0);
    do_req(2'b00, 32'd100, 32'd7, 32'd14, 1'b0);
    do_req(2'b10, 32'd100, 32'd7, 32'd2, 1'b0);
    do_req(2'b00, 32'h8000_0000, 32'd2, 32'hC000_0000, 1'b0);

    // Flush in the same cycle as a request: nothing accepted
    wait_ready();
    p0 = pulses;
    i_op = 2'b01; i_a = 32'd8; i_b = 32'd2; i_valid = 1'b1; i_flush = 1'b1;
    @(negedge clk);
    i_valid = 1'b0; i_flush = 1'b0;
    repeat (3) @(negedge clk);
    chk("flush_same_ready", {31'd0, o_ready}, 32'd1);
    chk("flush_same_pulses", pulses - p0, 32'd0);

    // Flush five cycles into WAIT, then drain
    dlat = 20;
    wait_ready();
    i_op = 2'b00; i_a = 32'd300; i_b = 32'd7; i_valid = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    i_flush = 1'b1;
    @(posedge clk);
    #1;
    i_flush = 1'b0;
    @(negedge clk);
    chk("drain_ready", {31'd0, o_ready}, 32'd0);
    chk("drain_stall", {31'd0, o_stall}, 32'd1);
    n = 0;
    while (i_div_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("drain_resp_wait", {31'd0, (n < 100)}, 32'd1);
    chk("drain_ready_at_resp", {31'd0, o_ready}, 32'd0);
    @(negedge clk);
    #1;
    chk("drain_ready_after", {31'd0, o_ready}, 32'd1);
    chk("drain_stall_after", {31'd0, o_stall}, 32'd0);
    dlat = 4;
    do_req(2'b01, 32'd1000, 32'd10, 32'd100, 1'b0);

    // Divider never answers
    div_en = 1'b0;
    do_req(2'b01, 32'd9, 32'd3, 32'd0, 1'b1);
    div_en = 1'b1;
    do_req(2'b11, 32'd9, 32'd4, 32'd1, 1'b0);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
- Initiator side of the iterative integer divider handshake, sitting between the EX stage and the divider datapath.
- Accepts RV32M DIV/DIVU/REM/REMU requests and resolves divide-by-zero and signed overflow locally.
- For all other cases it sends unsigned magnitudes to the divider with a one-cycle valid pulse, waits for the divider's valid, applies sign fix-up and returns one registered result.
- Asserts a stall towards the pipeline while busy.

Parameters:
TIMEOUT_CYCLES, 64, max cycles in WAIT before giving up on the divider; must be > divider latency (≥33).
CNT_W, 7, width of timeout counter; must hold TIMEOUT_CYCLES.

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_valid  in  1  request strobe from EX; accepted only when o_ready=1
o_ready  out  1  high only in IDLE
i_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
i_a  in  32  dividend (rs1)
i_b  in  32  divisor (rs2)
i_flush  in  1  pipeline flush; abandons the current request
o_stall  out  1  high in ISSUE/WAIT, and in IDLE while a flushed response is being drained
o_valid  out  1  one-cycle result strobe
o_result  out  32  quotient or remainder per latched op
o_timeout  out  1  one-cycle strobe with o_valid when the divider did not respond
o_div_valid  out  1  one-cycle request pulse to divider
o_div_a  out  32  unsigned dividend magnitude
o_div_b  out  32  unsigned divisor magnitude
i_div_valid  in  1  divider completion strobe
i_div_quotient  in  32  unsigned quotient
i_div_remainder  in  32  unsigned remainder

Behaviour:
- Reset (async, i_rst_n=0): state=IDLE, all outputs 0 except o_ready=1; latched operands, drain flag and counter cleared. Reset mid-operation abandons everything; a later stray i_div_valid is ignored because state is IDLE and the drain flag is 0.
- Accept: on i_valid && o_ready, latch op, a, b, and the signs: sq = a[31]^b[31] for signed ops, sr = a[31] for signed ops.
- Special cases on accept (divider not used, next state DONE):
  - b==0: quotient 0xFFFFFFFF, remainder = a.
  - signed op with a==0x80000000 and b==0xFFFFFFFF: quotient 0x80000000, remainder 0.
- Otherwise: magnitudes |a|, |b| for signed ops (two's complement negate, so 0x80000000 maps to 0x80000000); raw values for unsigned ops. Next state ISSUE.
- ISSUE: o_div_valid=1 for exactly one cycle with o_div_a/o_div_b stable; then go to WAIT and clear the counter.
- WAIT: counter increments every cycle.
  - i_div_valid: capture q or r per op, negate if the matching sign flag is set, then go to DONE.
  - Counter reaches TIMEOUT_CYCLES-1 without i_div_valid: go to DONE with result 0 and o_timeout=1.
- DONE: o_valid=1 for one cycle with o_result; o_result holds its value after that. Next state IDLE.
- Latency, accept edge to o_valid high:
  - Special case: 1 cycle.
  - Normal: divider latency + 2 cycles (+1 ISSUE, +1 registered output).
- Flush:
  - In ISSUE or DONE: return to IDLE, no o_valid.
  - In WAIT: return to IDLE with the drain flag set. While draining, o_ready=0 and o_stall=1 until i_div_valid is seen or the timeout expires; no o_valid or o_timeout is produced.
  - Flush in the same cycle as i_valid: the request is not accepted.
- i_div_valid outside WAIT or drain: ignored.
- i_valid while o_ready=0: ignored; no queueing.

Optional Feature:
- Macro DIV_RESULT_CACHE_EN.
- When defined: a single-entry cache stores the last completed divider operands (a, b, signed/unsigned) with both the final quotient and the final remainder. A request matching the entry takes the 1-cycle special-case path using the cached value, without touching the divider. The entry is written only on a non-timeout divider completion and invalidated by reset. Flush does not invalidate it.
- When undefined: every non-special request goes through the divider.

Test Plan:
- DIV a=-7 (0xFFFFFFF9), b=2 -> o_div_a=7, o_div_b=2, one o_div_valid pulse; divider returns q=3, r=1 -> o_result=0xFFFFFFFD, o_valid 1 cycle.
- REM a=-7, b=2 -> 0xFFFFFFFF. REMU a=0xFFFFFFF9, b=2 -> 0x00000001.
- DIVU a=5, b=0 -> 0xFFFFFFFF one cycle after accept, no o_div_valid. REM a=5, b=0 -> 5.
- DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000, 1 cycle, divider untouched. REM of the same pair -> 0.
- Flush 5 cycles into WAIT -> no o_valid; o_ready stays 0 until the divider responds, then 1. The next request gets its own correct result.
- Divider never responds -> o_valid with o_timeout=1, o_result=0 at TIMEOUT_CYCLES+1 cycles after accept. With DIV_RESULT_CACHE_EN: DIV 100/7 then REM 100/7 -> second result 2 in 1 cycle, no o_div_valid.
